axi_lite_starvation_monitor: RTL and testbench

- Passive, synthesizable monitor for the write channels of NUM_CH AXI4-Lite masters that share one interconnect.
- Timestamps each AW handshake and matches it to its B handshake to measure per-channel write latency, counts error responses, and flags timeouts.
- Gives the attack/defence benches an in-fabric, per-channel starvation measurement in place of testbench-only bookkeeping.
- Sits beside the interconnect slave ports; it only observes and never drives AXI signals.

---
 rtl/axi_lite_starvation_monitor.sv | 236 +++++++++++++++++++++++
 tb/tb_axi_lite_starvation_monitor.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_starvation_monitor.sv
// -----------------------------------------------------------------------------
// axi_lite_starvation_monitor
//
// Passive monitor for the write channels of NUM_CH AXI4-Lite masters sharing
// one interconnect. Each AW handshake pushes a timestamp into a per-channel
// FIFO. The matching B handshake pops it, which yields the write latency. The
// monitor also counts error responses, orphan B responses and FIFO overflows,
// and flags writes that stay outstanding for TIMEOUT_CYC cycles or longer.
// It never drives any AXI signal.
//
// Optional feature: define STARVE_MON_MAXLAT_EN to build a per-channel
// max-latency register, read as field 6. Without it, field 6 reads 0.
//
// Ports:
//   clock, reset_n          clock; asynchronous active-low reset
//   aw_valid/aw_ready       per-channel AW handshake, one bit per channel
//   b_valid/b_ready/b_resp  per-channel B handshake; BRESP of ch i is [2i+1:2i]
//   stat_clear              synchronous clear of counters and sticky flags
//   stat_ch/stat_field      readout select
//   stat_data               registered readout, 1-cycle latency
//   timeout_flag            sticky per-channel timeout indication
//   overflow_flag           sticky per-channel timestamp-FIFO overflow
//   starve_alarm            registered OR of timeout_flag
//
// Readout fields: 0 completed, 1 errors, 2 timeouts, 3 lat_sum, 4 overflow,
// 5 orphan, 6 max latency, 7 outstanding count. stat_ch >= NUM_CH reads 0.
// MAX_OUTST must be a power of two, 2 or larger.
// -----------------------------------------------------------------------------
module axi_lite_starvation_monitor #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 32,
  parameter int LAT_W       = 16,
  parameter int TIMEOUT_CYC = 5000,
  parameter int MAX_OUTST   = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_CH-1:0]     aw_valid,
  input  logic [NUM_CH-1:0]     aw_ready,
  input  logic [NUM_CH-1:0]     b_valid,
  input  logic [NUM_CH-1:0]     b_ready,
  input  logic [2*NUM_CH-1:0]   b_resp,
  input  logic                  stat_clear,
  input  logic [2:0]            stat_ch,
  input  logic [2:0]            stat_field,
  output logic [CNT_W-1:0]      stat_data,
  output logic [NUM_CH-1:0]     timeout_flag,
  output logic [NUM_CH-1:0]     overflow_flag,
  output logic                  starve_alarm
);

  localparam int PTR_W = $clog2(MAX_OUTST);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [LAT_W-1:0] TIMEOUT_L = LAT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef struct packed {
    logic [CNT_W-1:0] completed;
    logic [CNT_W-1:0] errors;
    logic [CNT_W-1:0] timeouts;
    logic [CNT_W-1:0] lat_sum;
    logic [CNT_W-1:0] overflow;
    logic [CNT_W-1:0] orphan;
  } ch_stats_t;

  // Per-channel state gathered for the readout mux.
  ch_stats_t        stats_v  [NUM_CH];
  logic [OCC_W-1:0] occ_v    [NUM_CH];
  logic [LAT_W-1:0] maxlat_v [NUM_CH];

  logic [LAT_W-1:0] ts_q, ts_d;
  logic [CNT_W-1:0] stat_data_q, stat_data_d;
  logic             starve_alarm_q, starve_alarm_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [LAT_W-1:0]     ts_mem [MAX_OUTST];
    logic [MAX_OUTST-1:0] tmo_mem;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]     occ_q, occ_d;
    ch_stats_t            stats_q, stats_d;
    logic                 tflag_q, tflag_d, oflag_q, oflag_d;
    logic                 aw_hs, b_hs, empty, full, pop, push, head_tmo, tmo_hit;
    logic [LAT_W-1:0]     age;
    logic [CNT_W:0]       lat_acc;

    assign aw_hs = aw_valid[g] & aw_ready[g];
    assign b_hs  = b_valid[g] & b_ready[g];
    assign empty = (occ_q == '0);
    assign full  = (occ_q == OCC_W'(MAX_OUTST));
    assign pop   = b_hs & ~empty;
    // A full FIFO still takes the push when the head leaves in the same cycle.
    assign push  = aw_hs & (~full | pop);

    assign head_tmo = tmo_mem[rd_ptr_q];
    // Modulo difference: the head's age, and its latency when it is popped.
    assign age      = ts_q - ts_mem[rd_ptr_q];
    // A head completing this cycle is a normal completion, not a timeout.
    assign tmo_hit  = ~empty & ~pop & ~head_tmo & (age >= TIMEOUT_L);
    assign lat_acc  = {1'b0, stats_q.lat_sum} + (CNT_W+1)'(age);

    always_comb begin
      // NOTE: every output of this block gets a default first so no path can
      // leave one unassigned and infer a latch.
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      occ_d    = occ_q;
      stats_d  = stats_q;
      tflag_d  = tflag_q;
      oflag_d  = oflag_q;

      if (pop) begin
        rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        stats_d.completed = stats_q.completed + CNT_ONE;
        if (b_resp[2*g +: 2] != 2'b00) stats_d.errors = stats_q.errors + CNT_ONE;
        if (!head_tmo) stats_d.lat_sum = lat_acc[CNT_W] ? '1 : lat_acc[CNT_W-1:0];
      end else if (b_hs) begin
        stats_d.orphan = stats_q.orphan + CNT_ONE;
      end

      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else if (aw_hs) begin
        stats_d.overflow = stats_q.overflow + CNT_ONE;
        oflag_d          = 1'b1;
      end

      if (push && !pop)      occ_d = occ_q + OCC_W'(1);
      else if (!push && pop) occ_d = occ_q - OCC_W'(1);

      if (tmo_hit) begin
        stats_d.timeouts = stats_q.timeouts + CNT_ONE;
        tflag_d          = 1'b1;
      end

      // Clear wins over any increment; FIFO bookkeeping is left untouched so
      // in-flight writes are still matched afterwards.
      if (stat_clear) begin
        stats_d = '0;
        tflag_d = 1'b0;
        oflag_d = 1'b0;
      end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        occ_q    <= '0;
        stats_q  <= '0;
        tflag_q  <= 1'b0;
        oflag_q  <= 1'b0;
      end else begin
        rd_ptr_q <= rd_ptr_d;
        wr_ptr_q <= wr_ptr_d;
        occ_q    <= occ_d;
        stats_q  <= stats_d;
        tflag_q  <= tflag_d;
        oflag_q  <= oflag_d;
      end
    end

    // NOTE: the storage array has no reset; emptying the FIFO through the
    // pointers and occupancy is enough, since only occupied slots are read.
    always_ff @(posedge clock) begin
      if (push) begin
        ts_mem[wr_ptr_q]  <= ts_q;
        tmo_mem[wr_ptr_q] <= 1'b0;
      end
      // Slots never alias here: a hit implies a non-empty FIFO with no pop,
      // so a push into the head slot is impossible in the same cycle.
      if (tmo_hit) tmo_mem[rd_ptr_q] <= 1'b1;
    end

`ifdef STARVE_MON_MAXLAT_EN
    logic [LAT_W-1:0] maxlat_q, maxlat_d;

    always_comb begin
      maxlat_d = maxlat_q;
      if (pop && !head_tmo && (age > maxlat_q)) maxlat_d = age;
      if (stat_clear) maxlat_d = '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) maxlat_q <= '0;
      else          maxlat_q <= maxlat_d;
    end

    assign maxlat_v[g] = maxlat_q;
`else
    assign maxlat_v[g] = '0;
`endif

    assign stats_v[g]       = stats_q;
    assign occ_v[g]         = occ_q;
    assign timeout_flag[g]  = tflag_q;
    assign overflow_flag[g] = oflag_q;
  end

  always_comb begin
    ts_d           = ts_q + LAT_W'(1);
    starve_alarm_d = stat_clear ? 1'b0 : (|timeout_flag);
    stat_data_d    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (stat_ch == 3'(c)) begin
        case (stat_field)
          3'd0: stat_data_d = stats_v[c].completed;
          3'd1: stat_data_d = stats_v[c].errors;
          3'd2: stat_data_d = stats_v[c].timeouts;
          3'd3: stat_data_d = stats_v[c].lat_sum;
          3'd4: stat_data_d = stats_v[c].overflow;
          3'd5: stat_data_d = stats_v[c].orphan;
          3'd6: stat_data_d = CNT_W'(maxlat_v[c]);
          3'd7: stat_data_d = CNT_W'(occ_v[c]);
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ts_q           <= '0;
      stat_data_q    <= '0;
      starve_alarm_q <= 1'b0;
    end else begin
      ts_q           <= ts_d;
      stat_data_q    <= stat_data_d;
      starve_alarm_q <= starve_alarm_d;
    end
  end

  assign stat_data    = stat_data_q;
  assign starve_alarm = starve_alarm_q;

endmodule

// File: tb/tb_axi_lite_starvation_monitor.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_starvation_monitor
//
// Directed scenarios followed by randomized traffic. The reference model is
// kept as one queue of {timestamp, timed_out} records per channel, plus plain
// counters. The model advances on every rising edge. A compare process checks
// every DUT output against the model on each falling edge. Literal checks pin
// both the DUT and the model in the directed scenarios.
// -----------------------------------------------------------------------------
module tb_axi_lite_starvation_monitor;

  localparam int NUM_CH      = 2;
  localparam int CNT_W       = 32;
  localparam int LAT_W       = 16;
  localparam int TIMEOUT_CYC = 100;
  localparam int MAX_OUTST   = 4;

  logic                clock = 1'b0;
  logic                reset_n = 1'b1;
  logic [NUM_CH-1:0]   aw_valid = '0, aw_ready = '0, b_valid = '0, b_ready = '0;
  logic [2*NUM_CH-1:0] b_resp = '0;
  logic                stat_clear = 1'b0;
  logic [2:0]          stat_ch = '0, stat_field = '0;
  logic [CNT_W-1:0]    stat_data;
  logic [NUM_CH-1:0]   timeout_flag, overflow_flag;
  logic                starve_alarm;

  int n_checks = 0;
  int n_errors = 0;

  axi_lite_starvation_monitor #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .LAT_W(LAT_W),
    .TIMEOUT_CYC(TIMEOUT_CYC), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .aw_valid(aw_valid), .aw_ready(aw_ready),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
    .stat_clear(stat_clear), .stat_ch(stat_ch), .stat_field(stat_field),
    .stat_data(stat_data), .timeout_flag(timeout_flag),
    .overflow_flag(overflow_flag), .starve_alarm(starve_alarm)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct { int unsigned ts; bit tmo; } ent_t;

  ent_t            mq    [NUM_CH][$];
  int unsigned     m_cnt [NUM_CH][6];  // completed, errors, timeouts, lat_sum, overflow, orphan
  int unsigned     m_max [NUM_CH];
  bit [NUM_CH-1:0] m_tflag = '0, m_oflag = '0;
  bit              m_alarm = 1'b0;
  int unsigned     m_ts = 0;
  int unsigned     m_data = 0;

  function automatic int unsigned model_read(input int ch, input int f);
    if (ch >= NUM_CH) return 0;
    case (f)
      6: begin
`ifdef STARVE_MON_MAXLAT_EN
        return m_max[ch];
`else
        return 0;
`endif
      end
      7:       return mq[ch].size();
      default: return m_cnt[ch][f];
    endcase
  endfunction

  task automatic model_clear_stats();
    for (int c = 0; c < NUM_CH; c++) begin
      for (int f = 0; f < 6; f++) m_cnt[c][f] = 0;
      m_max[c] = 0;
    end
    m_tflag = '0;
    m_oflag = '0;
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) mq[c].delete();
    model_clear_stats();
    m_alarm = 1'b0;
    m_ts    = 0;
    m_data  = 0;
  endtask

  task automatic model_step();
    bit nx_alarm;
    nx_alarm = !stat_clear && (m_tflag != '0);
    m_data   = model_read(int'(stat_ch), int'(stat_field));
    for (int c = 0; c < NUM_CH; c++) begin
      bit               aw_hs, b_hs, do_pop;
      ent_t             e;
      int unsigned      lat;
      longint unsigned  s;
      aw_hs  = aw_valid[c] && aw_ready[c];
      b_hs   = b_valid[c] && b_ready[c];
      do_pop = b_hs && (mq[c].size() > 0);
      // Oldest write, not completing now, that has waited long enough.
      if (!do_pop && mq[c].size() > 0) begin
        e = mq[c][0];
        if (!e.tmo && (((m_ts - e.ts) & 32'hFFFF) >= TIMEOUT_CYC)) begin
          e.tmo     = 1'b1;
          mq[c][0]  = e;
          m_cnt[c][2]++;
          m_tflag[c] = 1'b1;
        end
      end
      if (do_pop) begin
        e = mq[c].pop_front();
        m_cnt[c][0]++;
        if (b_resp[2*c +: 2] != 2'b00) m_cnt[c][1]++;
        if (!e.tmo) begin
          lat = (m_ts - e.ts) & 32'hFFFF;
          s   = longint'(m_cnt[c][3]) + lat;
          m_cnt[c][3] = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
          if (lat > m_max[c]) m_max[c] = lat;
        end
      end else if (b_hs) begin
        m_cnt[c][5]++;
      end
      if (aw_hs) begin
        if (mq[c].size() < MAX_OUTST) begin
          e.ts  = m_ts;
          e.tmo = 1'b0;
          mq[c].push_back(e);
        end else begin
          m_cnt[c][4]++;
          m_oflag[c] = 1'b1;
        end
      end
    end
    if (stat_clear) model_clear_stats();
    m_alarm = nx_alarm;
    m_ts    = (m_ts + 1) & 32'hFFFF;
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) model_reset();
    else          model_step();
  end

  // ---------------------------------------------------------------- compare
  always @(negedge clock) begin
    check("stat_data",     stat_data,     m_data);
    check("timeout_flag",  timeout_flag,  m_tflag);
    check("overflow_flag", overflow_flag, m_oflag);
    check("starve_alarm",  starve_alarm,  m_alarm);
  end

  // ---------------------------------------------------------------- stimulus
  // Present one cycle of handshakes (called at a falling edge), then go idle.
  task automatic cyc(input logic [NUM_CH-1:0] aw, input logic [NUM_CH-1:0] b,
                     input logic [2*NUM_CH-1:0] resp, input logic clr);
    aw_valid = aw; aw_ready = aw; b_valid = b; b_ready = b; b_resp = resp; stat_clear = clr;
    @(negedge clock);
    aw_valid = '0; aw_ready = '0; b_valid = '0; b_ready = '0; b_resp = '0; stat_clear = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic read_stat(input int ch, input int f, output logic [CNT_W-1:0] val);
    stat_ch    = 3'(ch);
    stat_field = 3'(f);
    @(negedge clock);
    val = stat_data;
  endtask

  // AW on channel ch, B exactly `lat` cycles later.
  task automatic single_write(input int ch, input int lat, input logic [1:0] resp);
    logic [NUM_CH-1:0]   m;
    logic [2*NUM_CH-1:0] r;
    m = '0; m[ch] = 1'b1;
    r = '0; r[2*ch +: 2] = resp;
    cyc(m, '0, '0, 1'b0);
    idle(lat - 1);
    cyc('0, m, r, 1'b0);
  endtask

  logic [CNT_W-1:0] v;
  int               k;
  bit               found;
  int               pa, pb;

  initial begin
    #1 reset_n = 1'b0;
    idle(3);
    reset_n = 1'b1;

    // Reset state
    read_stat(0, 0, v); check("reset_completed", v, 0);
    check("reset_tflag", timeout_flag, 0);

    // Single write, latency 15, OKAY
    single_write(0, 15, 2'b00);
    read_stat(0, 0, v); check("sw_completed", v, 1);
    read_stat(0, 3, v); check("sw_lat_sum", v, 15);
    read_stat(0, 1, v); check("sw_errors", v, 0);
    read_stat(0, 7, v); check("sw_outstanding", v, 0);
    check("model_lat_sum", model_read(0, 3), 15);
    check("model_completed", model_read(0, 0), 1);

    // Error response on ch1 leaves ch0 alone
    single_write(1, 4, 2'b10);
    read_stat(1, 1, v); check("err_errors", v, 1);
    read_stat(1, 0, v); check("err_completed", v, 1);
    read_stat(0, 0, v); check("err_ch0_completed", v, 1);
    read_stat(0, 1, v); check("err_ch0_errors", v, 0);

    // Timeout: flag exactly TIMEOUT_CYC cycles after the AW, alarm one later
    cyc('0, '0, '0, 1'b1);
    stat_ch = 3'd0; stat_field = 3'd2;
    cyc(2'b01, '0, '0, 1'b0);
    found = 1'b0; k = 0;
    while (!found && k < 2*TIMEOUT_CYC) begin
      @(negedge clock);
      k++;
      found = timeout_flag[0];
    end
    check("tmo_delay", k, TIMEOUT_CYC);
    check("tmo_alarm_lag", starve_alarm, 0);
    @(negedge clock);
    check("tmo_alarm", starve_alarm, 1);
    read_stat(0, 2, v); check("tmo_count", v, 1);
    idle(180);
    cyc('0, 2'b01, '0, 1'b0);
    read_stat(0, 0, v); check("tmo_completed", v, 1);
    read_stat(0, 3, v); check("tmo_lat_sum", v, 0);

    // Overflow on ch1, then push+pop while full
    repeat (5) cyc(2'b10, '0, '0, 1'b0);
    read_stat(1, 4, v); check("ovf_count", v, 1);
    check("ovf_flag", overflow_flag, 2'b10);
    read_stat(1, 7, v); check("ovf_outstanding", v, 4);
    cyc(2'b10, 2'b10, '0, 1'b0);
    read_stat(1, 4, v); check("ovf_pushpop_count", v, 1);
    read_stat(1, 7, v); check("ovf_pushpop_outstanding", v, 4);
    repeat (4) cyc('0, 2'b10, '0, 1'b0);

    // Orphan, then clear on the same cycle as a B handshake
    cyc('0, 2'b01, '0, 1'b0);
    read_stat(0, 5, v); check("orphan_count", v, 1);
    cyc('0, 2'b01, '0, 1'b1);
    check("clr_tflag", timeout_flag, 0);
    check("clr_oflag", overflow_flag, 0);
    check("clr_alarm", starve_alarm, 0);
    for (int f = 0; f < 6; f++) begin
      read_stat(0, f, v);
      check($sformatf("clr_field%0d", f), v, 0);
    end

    // Max latency over 7, 20, 12
    single_write(0, 7, 2'b00);
    single_write(0, 20, 2'b00);
    single_write(0, 12, 2'b00);
    read_stat(0, 3, v); check("max_lat_sum", v, 39);
    read_stat(0, 6, v);
`ifdef STARVE_MON_MAXLAT_EN
    check("max_lat", v, 20);
`else
    check("max_lat", v, 0);
`endif

    // Asynchronous reset mid-operation
    cyc(2'b11, '0, '0, 1'b0);
    cyc(2'b01, '0, '0, 1'b0);
    read_stat(0, 7, v); check("prerst_outstanding", v, 2);
    #2 reset_n = 1'b0;
    #1;
    check("rst_stat_data", stat_data, 0);
    check("rst_oflag", overflow_flag, 0);
    idle(2);
    reset_n = 1'b1;
    read_stat(0, 7, v); check("rst_outstanding", v, 0);
    read_stat(0, 0, v); check("rst_completed", v, 0);

    // Randomized traffic, alternating drain-friendly and starving phases
    for (int i = 0; i < 4000; i++) begin
      pa = 40;
      case ((i / 400) % 3)
        0:       pb = 60;
        1:       pb = 3;
        default: pb = 30;
      endcase
      for (int c = 0; c < NUM_CH; c++) begin
        aw_valid[c] = ($urandom_range(99) < pa);
        aw_ready[c] = ($urandom_range(99) < 70);
        b_valid[c]  = ($urandom_range(99) < pb);
        b_ready[c]  = ($urandom_range(99) < 80);
      end
      b_resp     = (2*NUM_CH)'($urandom);
      stat_ch    = 3'($urandom_range(7));
      stat_field = 3'($urandom_range(7));
      stat_clear = ($urandom_range(299) == 0);
      @(negedge clock);
    end
    aw_valid = '0; aw_ready = '0; b_valid = '0; b_ready = '0; stat_clear = 1'b0;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
